spike_rate_pwm_decoder: RTL and testbench

Rate-decodes the excitatory output spike trains of the SNN core and turns them into per-channel motor PWM drive. Sits directly downstream of the SNN top level: consumes the `EXCNUM` output spike bits (`[0]` left, `[1]` right) and produces one PWM line per channel for the motor driver. Spikes are counted over a fixed window, converted to a saturated duty value, and applied to a free-running PWM generator only at PWM period boundaries.

---
 rtl/snn_motor_pkg.sv | 28 ++
 rtl/spike_window_counter.sv | 48 ++++
 rtl/spike_rate_pwm_decoder.sv | 100 ++++++++++
 tb/tb_spike_rate_pwm_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/snn_motor_pkg.sv
// Shared defaults, control-state encoding and the saturating duty helper for the
// spike-rate to motor-PWM path.
package snn_motor_pkg;

  localparam int unsigned DEF_EXCNUM = 2;
  localparam int unsigned DEF_WINDOW = 1024;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_PWM_W  = 8;
  localparam int unsigned DEF_SHIFT  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Shift at a width wide enough to never lose bits, then clamp to out_w bits.
  function automatic logic [31:0] sat_shift(input logic [31:0] val,
                                            input int unsigned shift,
                                            input int unsigned out_w);
    logic [63:0] wide;
    logic [63:0] max_val;
    wide    = {32'd0, val} << shift;
    max_val = (64'd1 << out_w) - 64'd1;
    return (wide > max_val) ? max_val[31:0] : wide[31:0];
  endfunction

endpackage

// File: rtl/spike_window_counter.sv
// Per-channel saturating spike counter; latches the closing window's count
// (including a spike on the close cycle) and restarts from zero.
module spike_window_counter
  import snn_motor_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             spike_i,
  input  logic             close_i,
  output logic [CNT_W-1:0] rate_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0] cnt_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    cnt_inc = (spike_i && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    if (en_i) begin
      if (close_i) begin
        rate_d = cnt_inc;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rate_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

  assign rate_o = rate_q;

endmodule

// File: rtl/spike_rate_pwm_decoder.sv
// Rate-decodes SNN output spikes over a fixed window and drives one PWM line per
// channel; new duty values only take effect at PWM period boundaries.
module spike_rate_pwm_decoder
  import snn_motor_pkg::*;
#(
  parameter int unsigned EXCNUM = DEF_EXCNUM,
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned PWM_W  = DEF_PWM_W,
  parameter int unsigned SHIFT  = DEF_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [EXCNUM-1:0]       spike_in,
  output logic [EXCNUM*CNT_W-1:0] rate_out,
  output logic                    rate_valid,
  output logic [EXCNUM*PWM_W-1:0] duty_out,
  output logic [EXCNUM-1:0]       pwm_out
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  state_e                  state_q, state_d;
  logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
  logic [PWM_W-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [EXCNUM*PWM_W-1:0] duty_q, duty_d, duty_pend;
  logic [EXCNUM-1:0]       pwm_q, pwm_d;
  logic                    rate_valid_q;
  logic                    win_close;
  logic                    pwm_wrap;
  logic                    run_active;

  assign win_close = en && (win_cnt_q == WIN_LAST);
  assign pwm_wrap  = en && (pwm_cnt_q == {PWM_W{1'b1}});

  for (genvar g = 0; g < EXCNUM; g++) begin : g_ch
    spike_window_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .spike_i(spike_in[g]),
      .close_i(win_close),
      .rate_o (rate_out[g*CNT_W +: CNT_W])
    );
    assign duty_pend[g*PWM_W +: PWM_W] =
      PWM_W'(sat_shift(32'(rate_out[g*CNT_W +: CNT_W]), SHIFT, PWM_W));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = HOLD;
      HOLD:    if (en)  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign run_active = (state_q != IDLE);

  // Duty reloads only as pwm_cnt wraps, so a rate landing on the wrap edge waits a period.
  always_comb begin
    win_cnt_d = win_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    if (en) begin
      win_cnt_d = win_close ? '0 : win_cnt_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (pwm_wrap && run_active) duty_d = duty_pend;
    end
    for (int i = 0; i < int'(EXCNUM); i++) begin
      pwm_d[i] = en && (pwm_cnt_q < duty_q[i*PWM_W +: PWM_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      pwm_q        <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
      rate_valid_q <= win_close;
    end
  end

  assign rate_valid = rate_valid_q;
  assign duty_out   = duty_q;
  assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_spike_rate_pwm_decoder.sv
// Directed bench: WINDOW=16, CNT_W=4, PWM_W=4; a second instance uses SHIFT=2.
module tb_spike_rate_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] spike_in = 2'b11;
  logic [7:0] rate_out, duty_out, rate_out_s, duty_out_s;
  logic [1:0] pwm_out, pwm_out_s;
  logic       rate_valid, rate_valid_s;

  int checks = 0;
  int failures = 0;
  int hi_m0, hi_m1, hi_s0, hi_s1, rv_early;

  always #5 clk = ~clk;

  spike_rate_pwm_decoder #(.EXCNUM(2), .WINDOW(16), .CNT_W(4), .PWM_W(4), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .rate_out(rate_out),
    .rate_valid(rate_valid), .duty_out(duty_out), .pwm_out(pwm_out));

  spike_rate_pwm_decoder #(.EXCNUM(2), .WINDOW(16), .CNT_W(4), .PWM_W(4), .SHIFT(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .rate_out(rate_out_s),
    .rate_valid(rate_valid_s), .duty_out(duty_out_s), .pwm_out(pwm_out_s));

  // Inputs change at the falling edge; outputs are read there too, half a cycle after the rising edge.
  task automatic tick(input logic e, input logic [1:0] s);
    en = e;
    spike_in = s;
    @(negedge clk);
  endtask

  // One full enabled window starting at win_cnt=0; bit k of each mask spikes at position k.
  task automatic run_window(input logic [15:0] m0, input logic [15:0] m1);
    hi_m0 = 0; hi_m1 = 0; hi_s0 = 0; hi_s1 = 0; rv_early = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, {m1[k], m0[k]});
      hi_m0 += int'(pwm_out[0]);
      hi_m1 += int'(pwm_out[1]);
      hi_s0 += int'(pwm_out_s[0]);
      hi_s1 += int'(pwm_out_s[1]);
      if (k < 15) rv_early += int'(rate_valid);
    end
    spike_in = 2'b00;
  endtask

  task automatic test_reset();
    int first;
    int n;
    rst = 1'b1;
    repeat (3) tick(1'b1, 2'b11);
    checks++; if ({rate_out, rate_valid} !== 9'h000) begin failures++; $display("FAIL reset_rate: got %h/%b required 00/0", rate_out, rate_valid); end
    checks++; if ({duty_out, pwm_out} !== 10'h000) begin failures++; $display("FAIL reset_pwm: got duty %h pwm %b required 00/00", duty_out, pwm_out); end
    checks++; if ({duty_out_s, pwm_out_s, rate_out_s} !== 18'h0) begin failures++; $display("FAIL reset_shift_dut: got %h %b %h required 0", duty_out_s, pwm_out_s, rate_out_s); end
    rst = 1'b0;
    first = 0;
    n = 0;
    while (first == 0 && n < 20) begin
      tick(1'b1, 2'b11);
      n++;
      if (rate_valid === 1'b1) first = n;
    end
    // Close on the 16th enabled edge, so rate_valid is high during the 17th cycle.
    checks++; if (first !== 16) begin failures++; $display("FAIL reset_first_valid: got edge %0d required 16", first); end
    checks++; if (rate_out !== 8'hFF) begin failures++; $display("FAIL reset_sat_rate: got %h required ff", rate_out); end
    checks++; if (duty_out !== 8'h00) begin failures++; $display("FAIL reset_duty_stale: got %h required 00", duty_out); end
  endtask

  task automatic test_rate_duty();
    run_window(16'h0551, 16'h0000);
    checks++; if (rv_early !== 0) begin failures++; $display("FAIL rd_valid_width: got %0d extra highs required 0", rv_early); end
    checks++; if ({rate_valid, rate_out} !== 9'h105) begin failures++; $display("FAIL rd_rate: got %b/%h required 1/05", rate_valid, rate_out); end
    checks++; if (duty_out !== 8'hFF) begin failures++; $display("FAIL rd_duty_prev: got %h required ff", duty_out); end
    run_window(16'h0000, 16'h0000);
    checks++; if (hi_m0 !== 15 || hi_m1 !== 15) begin failures++; $display("FAIL rd_pwm_max: got %0d/%0d required 15/15", hi_m0, hi_m1); end
    checks++; if (duty_out !== 8'h05) begin failures++; $display("FAIL rd_duty_new: got %h required 05", duty_out); end
    run_window(16'h0000, 16'h0000);
    checks++; if (hi_m0 !== 5 || hi_m1 !== 0) begin failures++; $display("FAIL rd_pwm_5of16: got %0d/%0d required 5/0", hi_m0, hi_m1); end
  endtask

  task automatic test_glitch_free();
    run_window(16'h0000, 16'h1110);
    checks++; if (rate_out !== 8'h30 || duty_out !== 8'h00) begin failures++; $display("FAIL gf_close: got rate %h duty %h required 30/00", rate_out, duty_out); end
    run_window(16'h0000, 16'h0000);
    checks++; if (hi_m1 !== 0) begin failures++; $display("FAIL gf_old_duty_holds: got %0d highs required 0", hi_m1); end
    checks++; if (duty_out !== 8'h30) begin failures++; $display("FAIL gf_duty_applied: got %h required 30", duty_out); end
    run_window(16'h0000, 16'h0000);
    checks++; if (hi_m0 !== 0 || hi_m1 !== 3) begin failures++; $display("FAIL gf_new_pwm: got %0d/%0d required 0/3", hi_m0, hi_m1); end
  endtask

  task automatic test_close_cycle_spike();
    run_window(16'h8000, 16'h0000);
    checks++; if (rate_out !== 8'h01) begin failures++; $display("FAIL ccs_counted: got %h required 01", rate_out); end
    run_window(16'h0001, 16'h0000);
    checks++; if (rate_out !== 8'h01) begin failures++; $display("FAIL ccs_next_from_zero: got %h required 01", rate_out); end
  endtask

  task automatic test_back_to_back();
    run_window(16'h00FF, 16'hFFFF);
    checks++; if (rate_out !== 8'hF8) begin failures++; $display("FAIL b2b_rate: got %h required f8", rate_out); end
  endtask

  task automatic test_saturation();
    run_window(16'h003F, 16'h0003);
    checks++; if (rate_out_s !== 8'h26) begin failures++; $display("FAIL sat_rate: got %h required 26", rate_out_s); end
    run_window(16'hFFFF, 16'h0000);
    checks++; if (duty_out_s !== 8'h8F) begin failures++; $display("FAIL sat_duty: got %h required 8f", duty_out_s); end
    checks++; if (duty_out !== 8'h26) begin failures++; $display("FAIL sat_unshifted_duty: got %h required 26", duty_out); end
    run_window(16'h0000, 16'h0000);
    checks++; if (hi_s0 !== 15 || hi_s1 !== 8) begin failures++; $display("FAIL sat_pwm: got %0d/%0d required 15/8", hi_s0, hi_s1); end
    checks++; if (hi_m0 !== 6 || hi_m1 !== 2) begin failures++; $display("FAIL sat_unshifted_pwm: got %0d/%0d required 6/2", hi_m0, hi_m1); end
  endtask

  task automatic test_enable_gating();
    int pwm_bad;
    int rv_bad;
    for (int k = 0; k < 5; k++) tick(1'b1, (k == 1 || k == 2) ? 2'b10 : 2'b00);
    checks++; if (pwm_out !== 2'b01) begin failures++; $display("FAIL gate_pre_pwm: got %b required 01", pwm_out); end
    pwm_bad = 0;
    rv_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 2'b11);
      pwm_bad += (pwm_out != 2'b00) ? 1 : 0;
      rv_bad += int'(rate_valid);
    end
    checks++; if (pwm_bad !== 0) begin failures++; $display("FAIL gate_pwm_stop: got %0d non-zero cycles required 0", pwm_bad); end
    checks++; if (rv_bad !== 0 || duty_out !== 8'h0F) begin failures++; $display("FAIL gate_hold: got valid %0d duty %h required 0/0f", rv_bad, duty_out); end
    tick(1'b1, 2'b00);
    checks++; if (pwm_out !== 2'b01) begin failures++; $display("FAIL gate_resume_pwm: got %b required 01", pwm_out); end
    for (int k = 1; k < 10; k++) tick(1'b1, (k == 2) ? 2'b10 : 2'b00);
    checks++; if (rate_valid !== 1'b0) begin failures++; $display("FAIL gate_no_early_close: got %b required 0", rate_valid); end
    tick(1'b1, 2'b00);
    checks++; if ({rate_valid, rate_out} !== 9'h130) begin failures++; $display("FAIL gate_late_close: got %b/%h required 1/30", rate_valid, rate_out); end
  endtask

  task automatic test_reset_mid_window();
    repeat (7) tick(1'b1, 2'b11);
    rst = 1'b1;
    repeat (2) tick(1'b1, 2'b11);
    checks++; if ({rate_out, rate_valid, duty_out, pwm_out} !== 19'h0) begin failures++; $display("FAIL mid_reset_clear: got %h %b %h %b required all 0", rate_out, rate_valid, duty_out, pwm_out); end
    rst = 1'b0;
    run_window(16'h0124, 16'h0000);
    checks++; if (rv_early !== 0) begin failures++; $display("FAIL mid_reset_no_valid: got %0d highs required 0", rv_early); end
    checks++; if ({rate_valid, rate_out} !== 9'h103) begin failures++; $display("FAIL mid_reset_rate: got %b/%h required 1/03", rate_valid, rate_out); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rate_duty();
    test_glitch_free();
    test_close_cycle_spike();
    test_back_to_back();
    test_saturation();
    test_enable_gating();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
